// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the fetch-stage PC sequencer.
//   state_e  : sequencer state machine encoding (BOOT, RUN, PEND)
//   src_e    : which redirect source won arbitration in a cycle
//   INSN_BYTES / align_word : instruction size and word alignment helper
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  // Sequencer states. BOOT is the post-reset settling cycle with no fetch,
  // RUN is normal fetching, PEND holds a redirect behind a stalled fetch.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Size of one instruction in bytes; the sequential PC step.
  localparam logic [31:0] INSN_BYTES = 32'd4;

  // Redirect source selected by the arbiter.
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_EX_BR   = 2'd1,
    SRC_EX_JALR = 2'd2,
    SRC_ID_JAL  = 2'd3
  } src_e;

  // Force a byte address onto an instruction boundary. Masking (rather than
  // slicing) keeps every input bit visibly consumed.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~(INSN_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/pc_sequencer_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Purely combinational redirect arbiter for the PC sequencer.
// Resolves the EX branch condition, picks the winning redirect source
// (EX JALR, then EX taken branch, then ID JAL), aligns its target and
// produces the flush strobes that belong to that source.
//
// Ports
//   enable_i          : sequencer is able to accept redirects (not in BOOT)
//   stall_i           : hazard freeze; suppresses the ID-stage JAL only
//   branch_ex_i       : conditional branch resolving in EX
//   bne_ex_i          : 1 = BNE (taken on !zero), 0 = BEQ (taken on zero)
//   zero_ex_i         : ALU zero flag for the EX branch
//   branch_target_i   : byte target of the EX branch
//   jalr_ex_i         : JALR resolving in EX
//   jalr_target_i     : byte target of the JALR
//   jal_id_i          : JAL decoded in ID
//   jal_target_i      : byte target of the JAL
//   src_o             : winning redirect source (SRC_NONE if none)
//   target_o          : word-aligned target of the winning source
//   flush_if_o        : kill the instruction entering IF/ID
//   flush_id_o        : kill the instruction entering ID/EX
// ---------------------------------------------------------------------------
module pc_redirect_arb
  import pc_seq_pkg::*;
(
  input  logic        enable_i,
  input  logic        stall_i,
  input  logic        branch_ex_i,
  input  logic        bne_ex_i,
  input  logic        zero_ex_i,
  input  logic [31:0] branch_target_i,
  input  logic        jalr_ex_i,
  input  logic [31:0] jalr_target_i,
  input  logic        jal_id_i,
  input  logic [31:0] jal_target_i,
  output src_e        src_o,
  output logic [31:0] target_o,
  output logic        flush_if_o,
  output logic        flush_id_o
);

  logic taken;

  // BNE is taken when the operands differ (zero flag clear), BEQ when equal.
  assign taken = branch_ex_i & (bne_ex_i ? ~zero_ex_i : zero_ex_i);

  always_comb begin
    src_o      = SRC_NONE;
    target_o   = '0;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;

    if (enable_i) begin
      // EX sources are older in program order, so they win over ID and are
      // honoured even during a stall. The ID JAL is dropped under stall
      // because ID re-presents it once the freeze lifts.
      if (jalr_ex_i) begin
        src_o      = SRC_EX_JALR;
        target_o   = align_word(jalr_target_i);
        flush_if_o = 1'b1;
        flush_id_o = 1'b1;
      end else if (taken) begin
        src_o      = SRC_EX_BR;
        target_o   = align_word(branch_target_i);
        flush_if_o = 1'b1;
        flush_id_o = 1'b1;
      end else if (jal_id_i && !stall_i) begin
        src_o      = SRC_ID_JAL;
        target_o   = align_word(jal_target_i);
        flush_if_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program counter controller. Holds the PC, chooses between
// sequential increment and redirects (EX branch, EX JALR, ID JAL), runs the
// instruction-memory valid/ready handshake, honours hazard stalls, parks a
// redirect that arrives while a fetch is blocked, emits flush strobes and
// counts granted redirects.
//
// Parameters
//   RESET_PC : PC value loaded on reset
//   CNT_W    : width of the saturating redirect counter
//
// Ports
//   clk_i, rst_i       : clock; asynchronous active-high reset
//   stall_i            : hazard-unit freeze of IF/ID
//   branch_ex_i, bne_ex_i, zero_ex_i, branch_target_i : EX branch
//   jalr_ex_i, jalr_target_i                          : EX JALR
//   jal_id_i, jal_target_i                            : ID JAL
//   fetch_ready_i      : instruction memory accepts the request
//   fetch_valid_o      : fetch request valid (registered)
//   pc_current_o       : fetch address (registered)
//   pc_plus4_o         : pc_current_o + 4, modulo 2^32
//   flush_if_o         : kill instruction entering IF/ID
//   flush_id_o         : kill instruction entering ID/EX
//   redirect_count_o   : redirects granted since reset, saturating
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_ex_i,
  input  logic             bne_ex_i,
  input  logic             zero_ex_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jalr_ex_i,
  input  logic [31:0]      jalr_target_i,
  input  logic             jal_id_i,
  input  logic [31:0]      jal_target_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [31:0]      pc_current_o,
  output logic [31:0]      pc_plus4_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  src_e             arb_src;
  logic [31:0]      arb_target;
  logic             arb_flush_if;
  logic             arb_flush_id;
  logic             redirect;
  logic             accept;
  logic             pend_release;
  logic [31:0]      pc_plus4;

  // -------------------------------------------------------------------------
  // Redirect arbitration
  // -------------------------------------------------------------------------
  pc_redirect_arb u_arb (
    .enable_i        (state_q != BOOT),
    .stall_i         (stall_i),
    .branch_ex_i     (branch_ex_i),
    .bne_ex_i        (bne_ex_i),
    .zero_ex_i       (zero_ex_i),
    .branch_target_i (branch_target_i),
    .jalr_ex_i       (jalr_ex_i),
    .jalr_target_i   (jalr_target_i),
    .jal_id_i        (jal_id_i),
    .jal_target_i    (jal_target_i),
    .src_o           (arb_src),
    .target_o        (arb_target),
    .flush_if_o      (arb_flush_if),
    .flush_id_o      (arb_flush_id)
  );

  assign redirect = (arb_src != SRC_NONE);
  assign accept   = fetch_valid_q & fetch_ready_i;
  assign pc_plus4 = pc_q + INSN_BYTES;

  // -------------------------------------------------------------------------
  // Next-state / next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_release = 1'b0;

    unique case (state_q)
      BOOT: begin
        // One quiet cycle after reset before the first fetch is issued.
        state_d = RUN;
      end

      RUN: begin
        if (redirect) begin
          if (accept) begin
            pc_d = arb_target;
          end else begin
            // The memory is still looking at pc_q, so the address must not
            // move. Park the target until the blocked fetch completes.
            pend_pc_d = arb_target;
            state_d   = PEND;
          end
        end else if (accept && !stall_i) begin
          pc_d = pc_plus4;
        end
      end

      PEND: begin
        // A younger redirect replaces the parked one; it has already
        // flushed whatever the older target would have fetched.
        if (redirect) begin
          pend_pc_d = arb_target;
        end
        if (accept) begin
          pc_d         = redirect ? arb_target : pend_pc_q;
          pend_pc_d    = '0;
          pend_release = 1'b1;
          state_d      = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    // Fetch is requested in every state except BOOT.
    fetch_valid_d = (state_d != BOOT);

    cnt_d = cnt_q;
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      fetch_valid_q <= fetch_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign fetch_valid_o    = fetch_valid_q;
  assign pc_current_o     = pc_q;
  assign pc_plus4_o       = pc_plus4;
  // The word fetched while a redirect was parked came from the old path,
  // so its acceptance also kills the IF/ID entry.
  assign flush_if_o       = arb_flush_if | pend_release;
  assign flush_id_o       = arb_flush_id;
  assign redirect_count_o = cnt_q;

  // Two EX redirect sources in the same cycle cannot come from one
  // instruction and indicates a broken decoder upstream.
  a_no_jalr_with_branch : assert property (
    @(posedge clk_i) disable iff (rst_i) !(jalr_ex_i && branch_ex_i)
  );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller for the fetch-stage program counter. It holds the PC register and selects the next PC from sequential increment, taken branch, JAL or JALR. It also arbitrates simultaneous redirect requests, handles the instruction-memory fetch handshake and hazard stalls, and emits pipeline flush strobes. It sits between the hazard unit, the ID/EX redirect sources and the instruction memory, and replaces the free-running PC register with its separate select modules.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 16: width of the redirect performance counter.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit freeze of IF/ID (load-use)
- branch_ex  in  1  conditional branch resolving in EX
- bne_ex  in  1  branch is BNE (taken on ~zero), else BEQ (taken on zero)
- zero_ex  in  1  ALU zero flag for branch_ex
- branch_target  in  32  byte target of EX branch
- jalr_ex  in  1  JALR resolving in EX
- jalr_target  in  32  byte target of JALR
- jal_id  in  1  JAL decoded in ID
- jal_target  in  32  byte target of JAL
- fetch_ready  in  1  instruction memory accepts request
- fetch_valid  out  1  fetch request valid
- pc_current  out  32  fetch address (registered)
- pc_plus4  out  32  pc_current + 4
- flush_if  out  1  kill instruction entering IF/ID
- flush_id  out  1  kill instruction entering ID/EX
- redirect_count  out  CNT_W  number of redirects taken since reset, saturating

## Operation
- States: BOOT, RUN, PEND.
- Reset values: state=BOOT, pc_current=RESET_PC, fetch_valid=0, flushes=0, pending cleared, redirect_count=0.
- BOOT lasts one cycle after reset deasserts and then moves to RUN; no fetch is issued in BOOT.
- RUN: fetch_valid=1. A fetch is accepted in a cycle where fetch_valid & fetch_ready.
- Taken branch: taken = branch_ex & (bne_ex ? ~zero_ex : zero_ex).
- Redirect priority: EX source (jalr_ex, else taken branch) beats jal_id. jalr_ex and branch_ex together is illegal and asserted in simulation.
- An EX redirect asserts flush_if=1 and flush_id=1. A JAL redirect asserts flush_if=1 only.
- jal_id is ignored while stall=1, because ID re-presents the JAL after the stall. An EX redirect overrides stall.
- All targets have bits [1:0] forced to 0. Arithmetic is 32-bit modulo, and pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- Next PC in RUN, highest priority first:
  - accepted fetch with a redirect → redirect target;
  - accepted fetch without a redirect → pc_plus4 if !stall, else hold;
  - fetch not accepted → hold.
- Redirect while the fetch is not accepted: the address must stay stable, so store the target in pend_pc and go to PEND. The flush strobes still fire in this cycle.
- PEND: fetch_valid=1 at the old pc_current.
  - A new redirect overwrites pend_pc and fires its flushes.
  - On acceptance, pc_current ← pend_pc, flush_if=1 (the fetched word is wrong-path), then return to RUN.
- redirect_count increments once per cycle in which a redirect is granted and saturates at all-ones.

## Timing
- pc_current, fetch_valid and state are registered. flush_if, flush_id and pc_plus4 are combinational from the current inputs and state.
- Redirect latency: a redirect granted in cycle N with fetch_ready=1 gives pc_current=target in N+1.
- Blocked redirect: pc_current=target one cycle after the first accepted fetch.
- pc_current never changes while fetch_valid=1 and fetch_ready=0.
- Reset asserted mid-operation returns to BOOT in the same instant and drops the pending redirect. No flush strobe is produced by reset.

## Structure
- Package pc_seq_pkg holds:
  - state enum {BOOT, RUN, PEND};
  - INSN_BYTES=4;
  - redirect-source enum {SRC_NONE, SRC_EX_BR, SRC_EX_JALR, SRC_ID_JAL}.
- Sub-module pc_redirect_arb is purely combinational. It computes taken, the selected source, the aligned target and the flush strobes. The top level keeps the state machine, the PC register, the pending buffer and the counter.

## Test plan
- Boot: release reset with RESET_PC=32'h100 → fetch_valid=0 for one cycle, then PC sequence 100, 104, 108 with fetch_ready=1.
- Branch: PC=0x20, branch_ex=1, bne_ex=1, zero_ex=0, target=0x80 → flush_if=flush_id=1, next PC 0x80, redirect_count=1. The same stimulus with zero_ex=1 gives no redirect and next PC 0x24.
- Priority: jal_id (target 0x40) together with jalr_ex (target 0x203) → next PC 0x200, flush_id=1.
- Stall: stall=1 for 3 cycles at PC=0x10 → PC holds at 0x10 and jal_id is ignored; after release, PC goes to 0x14.
- Blocked fetch: fetch_ready=0 at PC=0x30, jal_id to 0x90, then fetch_ready=1 two cycles later → PC stays 0x30 until acceptance, flush_if is pulsed at the redirect and at acceptance, then PC=0x90.
- Reset in PEND, then release → pending target discarded, PC=RESET_PC.
